output_neuron_seq: RTL and testbench



---
 rtl/nn_pkg.sv | 18 +
 rtl/output_neuron_seq_if.sv | 26 ++
 rtl/neuron_weight_store.sv | 30 +++
 rtl/output_neuron_seq.sv | 118 +++++++++++
 tb/tb_output_neuron_seq.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: phase encodings, fixed-point constants and sequencer states shared by the output-neuron blocks
package nn_pkg;

    localparam logic [1:0] PH_FSETUP = 2'b00;
    localparam logic [1:0] PH_FWD    = 2'b10;
    localparam logic [1:0] PH_BSETUP = 2'b11;
    localparam logic [1:0] PH_BWD    = 2'b01;

    localparam logic [31:0] Q_ONE = 32'h0001_0000;

    typedef enum logic [2:0] {IDLE, FSETUP, FWD, BSETUP, BWD, COMMIT, RESP} seq_state_t;

    // Idle, commit and response all park the neuron in its setup encoding
    function automatic logic [1:0] phase_of(seq_state_t s);
        return s == FWD ? PH_FWD : s == BSETUP ? PH_BSETUP : s == BWD ? PH_BWD : PH_FSETUP;
    endfunction

endpackage

// File: rtl/output_neuron_seq_if.sv
// output_neuron_seq_if: sample-in / result-out handshake bundle between the hidden layer and the sequencer
interface output_neuron_seq_if #(
    parameter int N    = 30,
    parameter int BITS = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [N-1:0][BITS-1:0] in_x;
    logic [BITS-1:0]        in_y_true;
    logic                   in_train;
    logic                   out_valid;
    logic                   out_ready;
    logic [BITS-1:0]        out_y;
    logic [BITS-1:0]        out_yhat;
    logic [BITS-1:0]        out_dz;

    modport master (
        output in_valid, in_x, in_y_true, in_train, out_ready,
        input  in_ready, out_valid, out_y, out_yhat, out_dz
    );

    modport slave (
        input  in_valid, in_x, in_y_true, in_train, out_ready,
        output in_ready, out_valid, out_y, out_yhat, out_dz
    );
endinterface

// File: rtl/neuron_weight_store.sv
// neuron_weight_store: {w,b} register bank, slot 0 = bias, with single-slot load and bulk commit
module neuron_weight_store #(
    parameter int N    = 30,
    parameter int BITS = 32,
    parameter int IW   = $clog2(N + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [IW-1:0]          idx,
    input  logic [BITS-1:0]        data,
    input  logic                   commit,
    input  logic [N:0][BITS-1:0]   wout,
    output logic [N-1:0][BITS-1:0] w,
    output logic [BITS-1:0]        b
);
    logic [N:0][BITS-1:0] bank;

    // Commit only happens outside IDLE and loads only inside it, so the priority never actually arbitrates
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            bank <= '0;
        else if (commit)
            bank <= wout;
        else if (load)
            bank[idx] <= data;

    assign b = bank[0];
    assign w = bank[N:1];
endmodule

// File: rtl/output_neuron_seq.sv
// output_neuron_seq: sequences the sigmoid output neuron through forward/backward phases and owns its weights
module output_neuron_seq
    import nn_pkg::*;
#(
    parameter int N       = 30,
    parameter int BITS    = 32,
    parameter int FWD_CYC = N / 2 + 4,
    parameter int BWD_CYC = N + 4,
    parameter int IW      = $clog2(N + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output_neuron_seq_if.slave     bus,
    input  logic [BITS-1:0]        lr,
    input  logic                   wl_valid,
    input  logic [IW-1:0]          wl_idx,
    input  logic [BITS-1:0]        wl_data,
    output logic                   nrn_fp,
    output logic                   nrn_bp,
    output logic [N-1:0][BITS-1:0] nrn_x,
    output logic [N-1:0][BITS-1:0] nrn_w,
    output logic [BITS-1:0]        nrn_b,
    output logic [BITS-1:0]        nrn_y_true,
    output logic [BITS-1:0]        nrn_lr,
    input  logic [BITS-1:0]        nrn_y,
    input  logic [BITS-1:0]        nrn_yhat,
    input  logic [BITS-1:0]        nrn_dz,
    input  logic [N:0][BITS-1:0]   nrn_wout
);
    localparam int CMAX = BWD_CYC > FWD_CYC ? BWD_CYC : FWD_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    seq_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    ph_n;
    logic          train, accept, wl_load, commit, fwd_end, bwd_end;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            {nrn_fp, nrn_bp} <= PH_FSETUP;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            {nrn_fp, nrn_bp} <= ph_n;
        end

    // The down-counter is preloaded on the setup cycle so the phase lasts exactly its cycle budget
    always_comb begin
        state_n = state;
        cnt_n   = cnt == '0 ? cnt : cnt - 1'b1;
        unique case (state)
            IDLE:    state_n = accept ? FSETUP : IDLE;
            FSETUP: begin
                state_n = FWD;
                cnt_n   = CW'(FWD_CYC - 1);
            end
            FWD:     state_n = cnt != '0 ? FWD : train ? BSETUP : RESP;
            BSETUP: begin
                state_n = BWD;
                cnt_n   = CW'(BWD_CYC - 1);
            end
            BWD:     state_n = cnt != '0 ? BWD : COMMIT;
            COMMIT:  state_n = RESP;
            RESP:    state_n = bus.out_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ph_n         = phase_of(state_n);
        bus.in_ready = state == IDLE && !wl_valid;
        accept       = bus.in_valid && bus.in_ready;
        wl_load      = state == IDLE && wl_valid && wl_idx <= IW'(N);
        commit       = state == COMMIT;
        fwd_end      = state == FWD && cnt == '0;
        bwd_end      = state == BWD && cnt == '0;
        nrn_lr       = lr;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            train         <= 1'b0;
            nrn_x         <= '0;
            nrn_y_true    <= '0;
            bus.out_valid <= 1'b0;
            bus.out_y     <= '0;
            bus.out_yhat  <= '0;
            bus.out_dz    <= '0;
        end else begin
            bus.out_valid <= state_n == RESP;
            if (accept) begin
                nrn_x      <= bus.in_x;
                nrn_y_true <= bus.in_y_true;
                train      <= bus.in_train;
            end
            if (fwd_end) begin
                bus.out_y    <= nrn_y;
                bus.out_yhat <= nrn_yhat;
                bus.out_dz   <= '0;
            end
            if (bwd_end)
                bus.out_dz <= nrn_dz;
        end

    neuron_weight_store #(.N(N), .BITS(BITS), .IW(IW)) u_store (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (wl_load),
        .idx    (wl_idx),
        .data   (wl_data),
        .commit (commit),
        .wout   (nrn_wout),
        .w      (nrn_w),
        .b      (nrn_b)
    );
endmodule

// File: tb/tb_output_neuron_seq.sv
// tb_output_neuron_seq: directed bench with a mock neuron and a result scoreboard for output_neuron_seq
module tb_output_neuron_seq;
    import nn_pkg::*;

    localparam int N       = 30;
    localparam int BITS    = 32;
    localparam int FWD_CYC = N / 2 + 4;
    localparam int BWD_CYC = N + 4;
    localparam int IW      = $clog2(N + 1);

    typedef struct {
        logic [BITS-1:0] y;
        logic [BITS-1:0] yhat;
        logic [BITS-1:0] dz;
        int              lat;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [BITS-1:0]        lr = 32'hFFFF_F000;
    logic                   wl_valid = 1'b0;
    logic [IW-1:0]          wl_idx = '0;
    logic [BITS-1:0]        wl_data = '0;
    logic                   nrn_fp, nrn_bp;
    logic [N-1:0][BITS-1:0] nrn_x, nrn_w;
    logic [BITS-1:0]        nrn_b, nrn_y_true, nrn_lr;
    logic [BITS-1:0]        nrn_y = '0, nrn_yhat = '0, nrn_dz = '0;
    logic [N:0][BITS-1:0]   nrn_wout;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    output_neuron_seq_if #(.N(N), .BITS(BITS)) bus ();

    output_neuron_seq #(.N(N), .BITS(BITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .lr         (lr),
        .wl_valid   (wl_valid),
        .wl_idx     (wl_idx),
        .wl_data    (wl_data),
        .nrn_fp     (nrn_fp),
        .nrn_bp     (nrn_bp),
        .nrn_x      (nrn_x),
        .nrn_w      (nrn_w),
        .nrn_b      (nrn_b),
        .nrn_y_true (nrn_y_true),
        .nrn_lr     (nrn_lr),
        .nrn_y      (nrn_y),
        .nrn_yhat   (nrn_yhat),
        .nrn_dz     (nrn_dz),
        .nrn_wout   (nrn_wout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] phase_at(int k, logic tr);
        if (k == 0) return 2'b00;
        if (k <= FWD_CYC) return 2'b10;
        if (!tr) return 2'b00;
        if (k == FWD_CYC + 1) return 2'b11;
        if (k <= FWD_CYC + 1 + BWD_CYC) return 2'b01;
        return 2'b00;
    endfunction

    task automatic wl(input logic [IW-1:0] idx, input logic [BITS-1:0] data);
        wl_valid = 1'b1;
        wl_idx   = idx;
        wl_data  = data;
        @(negedge clk);
        wl_valid = 1'b0;
    endtask

    // One full sample: accept, trace phases until out_valid, check against the scoreboard, then drain
    task automatic run(input logic train, input logic [BITS-1:0] yt, input int hold);
        exp_t        e, got;
        int          k, ph_bad, unst;
        logic [96:0] snap;
        e.y    = nrn_y;
        e.yhat = nrn_yhat;
        e.dz   = train ? nrn_dz : '0;
        e.lat  = train ? FWD_CYC + BWD_CYC + 3 : FWD_CYC + 1;
        for (int i = 0; i < N; i++) bus.in_x[i] = $urandom;
        bus.in_y_true = yt;
        bus.in_train  = train;
        bus.out_ready = hold == 0;
        bus.in_valid  = 1'b1;
        #1;
        chk("accept_ready", bus.in_ready, 1);
        sb.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("latched_x", nrn_x === bus.in_x, 1);
        chk("latched_label", nrn_y_true, yt);
        ph_bad = 0;
        k = 0;
        while (!bus.out_valid && k < 200) begin
            if ({nrn_fp, nrn_bp} !== phase_at(k, train)) ph_bad++;
            @(negedge clk);
            k++;
        end
        chk("out_valid_seen", bus.out_valid, 1);
        got = sb.pop_front();
        chk("latency", k, got.lat);
        chk("phase_trace_errs", ph_bad, 0);
        chk("resp_phase", {nrn_fp, nrn_bp}, 2'b00);
        chk("out_y", bus.out_y, got.y);
        chk("out_yhat", bus.out_yhat, got.yhat);
        chk("out_dz", bus.out_dz, got.dz);
        unst = 0;
        snap = {bus.out_valid, bus.out_y, bus.out_yhat, bus.out_dz};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if ({bus.out_valid, bus.out_y, bus.out_yhat, bus.out_dz} !== snap || bus.in_ready !== 1'b0) unst++;
        end
        if (hold > 0) chk("hold_unstable", unst, 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("valid_dropped", bus.out_valid, 0);
        chk("idle_ready", bus.in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int nz;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y_true = '0;
        bus.in_train  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k <= N; k++) nrn_wout[k] = BITS'(k);
        repeat (2) @(negedge clk);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_phase", {nrn_fp, nrn_bp}, 2'b00);
        chk("rst_w", nrn_w == '0, 1);
        chk("rst_b", nrn_b, 0);
        chk("rst_out_y", bus.out_y, 0);
        rst_n = 1'b1;
        @(negedge clk);

        wl(0, 32'h0000_8000);
        wl(3, 32'hFFFF_0000);
        wl(31, 32'h0000_1234);
        chk("wl_bias", nrn_b, 32'h0000_8000);
        chk("wl_w2", nrn_w[2], 32'hFFFF_0000);
        nz = 0;
        for (int i = 0; i < N; i++) if (i != 2 && nrn_w[i] != '0) nz++;
        chk("wl_others_zero", nz, 0);

        for (int i = 0; i < N; i++) bus.in_x[i] = $urandom | 32'h1;
        bus.in_valid = 1'b1;
        wl_valid     = 1'b1;
        wl_idx       = 1;
        wl_data      = 32'h0002_0000;
        #1;
        chk("ready_during_load", bus.in_ready, 0);
        @(negedge clk);
        wl_valid = 1'b0;
        chk("wl_w0", nrn_w[0], 32'h0002_0000);
        chk("no_accept_x", nrn_x == '0, 1);
        chk("no_accept_phase", {nrn_fp, nrn_bp}, 2'b00);

        nrn_y    = 32'h0000_8000;
        nrn_yhat = Q_ONE;
        nrn_dz   = 32'hFFFF_8000;
        run(1'b0, Q_ONE, 0);

        run(1'b1, Q_ONE, 10);
        chk("commit_bias", nrn_b, 0);
        nz = 0;
        for (int i = 0; i < N; i++) if (nrn_w[i] !== BITS'(i + 1)) nz++;
        chk("commit_w_errs", nz, 0);
        chk("lr_pass", nrn_lr, lr);

        bus.in_train = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid_bwd_phase", {nrn_fp, nrn_bp}, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", bus.in_ready, 1);
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_w", nrn_w == '0, 1);
        chk("midrst_phase", {nrn_fp, nrn_bp}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        nrn_y    = 32'h0000_3000;
        nrn_yhat = '0;
        run(1'b0, '0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
